// File: rtl/key_event_decoder.sv
// key_event_decoder: turns a debounced key level into press/release/click/dclick/long-press pulses.
// Define AUTO_REPEAT_EN to add periodic repeat_pulse while the key is long-held.
module key_event_decoder #(
    parameter int unsigned LONG_CYCLES   = 100000000,
    parameter int unsigned DCLICK_CYCLES = 30000000,
    parameter int unsigned REPEAT_CYCLES = 20000000
) (
    input  logic clk,
    input  logic rst,
    input  logic key,
    output logic held,
    output logic press,
    output logic release_pulse,
    output logic click,
    output logic dclick,
    output logic long_press,
    output logic repeat_pulse
);
    typedef enum logic [2:0] {IDLE, DOWN1, UP1, DOWN2, LONG} state_t;

    state_t      state, state_n;
    logic [31:0] cnt, cnt_n;
    logic        key_d, rise, fall;
    logic        long_hit, click_hit, rep_hit;
    logic        click_n, dclick_n, long_n, rep_n;

    if (LONG_CYCLES < 2 || DCLICK_CYCLES < 2 || REPEAT_CYCLES < 2) begin : g_bad_param
        $error("key_event_decoder: cycle parameters must be at least 2");
    end

    assign rise      = key & ~key_d;
    assign fall      = ~key & key_d;
    assign long_hit  = cnt == LONG_CYCLES - 1;
    assign click_hit = cnt == DCLICK_CYCLES - 1;
    assign held      = key_d;

`ifdef AUTO_REPEAT_EN
    assign rep_hit = cnt == REPEAT_CYCLES - 1;
`else
    assign rep_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            key_d <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            key_d <= key;
        end
    end

    // A rise on the UP1 timeout clock wins over the click timeout.
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = rise ? DOWN1 : IDLE;
            DOWN1:   state_n = fall ? UP1 : long_hit ? LONG : DOWN1;
            UP1:     state_n = rise ? DOWN2 : click_hit ? IDLE : UP1;
            DOWN2:   state_n = fall ? IDLE : long_hit ? LONG : DOWN2;
            LONG:    state_n = fall ? IDLE : LONG;
            default: state_n = IDLE;
        endcase
    end

    // In LONG the counter only runs when auto-repeat is built in; it then wraps each period.
    always_comb begin
        cnt_n = cnt + 32'd1;
        if (state_n != state || state == IDLE)
            cnt_n = '0;
        else if (state == LONG)
`ifdef AUTO_REPEAT_EN
            cnt_n = rep_hit ? '0 : cnt + 32'd1;
`else
            cnt_n = cnt;
`endif
    end

    always_comb begin
        click_n  = state == UP1 && !rise && click_hit;
        dclick_n = state == DOWN2 && fall;
        long_n   = (state == DOWN1 || state == DOWN2) && !fall && long_hit;
        rep_n    = state == LONG && !fall && rep_hit;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            press         <= 1'b0;
            release_pulse <= 1'b0;
            click         <= 1'b0;
            dclick        <= 1'b0;
            long_press    <= 1'b0;
            repeat_pulse  <= 1'b0;
        end else begin
            press         <= rise;
            release_pulse <= fall;
            click         <= click_n;
            dclick        <= dclick_n;
            long_press    <= long_n;
            repeat_pulse  <= rep_n;
        end
    end
endmodule

// File: tb/tb_key_event_decoder.sv
// tb_key_event_decoder: directed gesture scenarios for key_event_decoder (LONG=20, DCLICK=10, REPEAT=5).
// Output vector order: {held, press, release, click, dclick, long_press, repeat_pulse}.
module tb_key_event_decoder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic key = 1'b0;
    logic held, press, release_pulse, click, dclick, long_press, repeat_pulse;
    logic [6:0] obs;
    int checks = 0;
    int errors = 0;

    key_event_decoder #(
        .LONG_CYCLES(20),
        .DCLICK_CYCLES(10),
        .REPEAT_CYCLES(5)
    ) dut (
        .clk(clk),
        .rst(rst),
        .key(key),
        .held(held),
        .press(press),
        .release_pulse(release_pulse),
        .click(click),
        .dclick(dclick),
        .long_press(long_press),
        .repeat_pulse(repeat_pulse)
    );

    always #5 clk = ~clk;

    assign obs = {held, press, release_pulse, click, dclick, long_press, repeat_pulse};

    // Drive inputs, take one active edge, then settle so outputs reflect that edge.
    task automatic step(input logic k, input logic r);
        key = k;
        rst = r;
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        for (int i = 0; i < 12; i++) step(1'b0, 1'b0);
    endtask

    task automatic test_reset();
        step(1'b1, 1'b1);
        checks++;
        if (obs !== 7'b0) begin
            errors++;
            $display("FAIL reset_key_high: got %b expected %b", obs, 7'b0);
        end
        step(1'b0, 1'b1);
        checks++;
        if (obs !== 7'b0) begin
            errors++;
            $display("FAIL reset_key_low: got %b expected %b", obs, 7'b0);
        end
        settle();
        checks++;
        if (obs !== 7'b0) begin
            errors++;
            $display("FAIL idle_after_reset: got %b expected %b", obs, 7'b0);
        end
    endtask

    task automatic test_single_tap();
        logic k;
        logic [6:0] exp;
        for (int i = 0; i < 20; i++) begin
            k = i < 5;
            step(k, 1'b0);
            exp = {k, i == 0, i == 5, i == 15, 1'b0, 1'b0, 1'b0};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL single_tap step %0d: got %b expected %b", i, obs, exp);
            end
        end
    endtask

    task automatic test_double_tap();
        logic k;
        logic [6:0] exp;
        for (int i = 0; i < 31; i++) begin
            k = i < 5 || (i >= 9 && i < 14);
            step(k, 1'b0);
            exp = {k, i == 0 || i == 9, i == 5 || i == 14, 1'b0, i == 14, 1'b0, 1'b0};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL double_tap step %0d: got %b expected %b", i, obs, exp);
            end
        end
    endtask

    task automatic test_dclick_boundary();
        logic k;
        logic [6:0] exp;
        for (int i = 0; i < 31; i++) begin
            k = i < 5 || (i >= 15 && i < 20);
            step(k, 1'b0);
            exp = {k, i == 0 || i == 15, i == 5 || i == 20, 1'b0, i == 20, 1'b0, 1'b0};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL dclick_boundary step %0d: got %b expected %b", i, obs, exp);
            end
        end
    endtask

    task automatic test_long_hold();
        logic k, rep;
        logic [6:0] exp;
        for (int i = 0; i < 55; i++) begin
            k = i < 40;
`ifdef AUTO_REPEAT_EN
            rep = i == 25 || i == 30 || i == 35;
`else
            rep = 1'b0;
`endif
            step(k, 1'b0);
            exp = {k, i == 0, i == 40, 1'b0, 1'b0, i == 20, rep};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL long_hold step %0d: got %b expected %b", i, obs, exp);
            end
        end
    endtask

    task automatic test_reset_mid_hold();
        logic k, r;
        logic [6:0] exp;
        for (int i = 0; i < 50; i++) begin
            k = i < 36;
            r = i == 10 || i == 11;
            step(k, r);
            exp = {k && !r, i == 0 || i == 12, i == 36, 1'b0, 1'b0, i == 32, 1'b0};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL reset_mid_hold step %0d: got %b expected %b", i, obs, exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_tap();
        settle();
        test_double_tap();
        settle();
        test_dclick_boundary();
        settle();
        test_long_hold();
        settle();
        test_reset_mid_hold();
        settle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
